ringbus_tx: RTL and testbench

RINGBUS_TX -- requirements
Module: ringbus_tx

---
 rtl/ringbus_tx.sv | 146 ++++++++++++++
 tb/tb_ringbus_tx.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ringbus_tx.sv
// Ringbus serial transmitter: start bit, WIDTH data bits MSB first, optional parity, then GAP idle cycles.
// Optional even parity bit is compiled in with `define RINGBUS_TX_PARITY_EN.
module ringbus_tx #(
    parameter int WIDTH = 32,
    parameter int GAP   = 2
) (
    input  logic             CLK,
    input  logic             MIB_MASTER_RESET,
    input  logic [WIDTH-1:0] t0_data,
    input  logic             t0_valid,
    output logic             t0_ready,
    output logic             o_ringbus,
    output logic             o_busy,
    output logic [15:0]      o_frames_sent
);

    // Counter widens only when WIDTH exceeds 32 so the last bit stays reachable.
    localparam int                CNT_W    = (WIDTH > 32) ? 6 : 5;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0]        GAP_LAST = 4'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RINGBUS_TX_PARITY_EN
        S_PARITY,
`endif
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [15:0]        frames_q, frames_d;
    logic               line_q, line_d;
    logic               busy_q, busy_d;
`ifdef RINGBUS_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    always_ff @(posedge CLK) begin
        if (MIB_MASTER_RESET) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            frames_q  <= '0;
            line_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef RINGBUS_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            frames_q  <= frames_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
`ifdef RINGBUS_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
`ifdef RINGBUS_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (t0_valid && t0_ready) begin
                    state_d = S_START;
                    shift_d = t0_data;
`ifdef RINGBUS_TX_PARITY_EN
                    parity_d = ^t0_data;
`endif
                end
            end
            S_START: begin
                state_d   = S_DATA;
                bit_cnt_d = '0;
            end
            S_DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
`ifdef RINGBUS_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
`ifdef RINGBUS_TX_PARITY_EN
            S_PARITY: begin
                if (GAP > 0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // The MSB is presented on the line as it is shifted out.
        if (state_d == S_DATA) shift_d = shift_q << 1;
    end

    always_comb begin
        t0_ready = (state_q == S_IDLE) && !MIB_MASTER_RESET;
        busy_d   = (state_d != S_IDLE);
        frames_d = frames_q;
        if (state_d == S_IDLE && state_q != S_IDLE) frames_d = frames_q + 16'd1;
        case (state_d)
            S_START:  line_d = 1'b1;
            S_DATA:   line_d = shift_q[WIDTH-1];
`ifdef RINGBUS_TX_PARITY_EN
            S_PARITY: line_d = parity_q;
`endif
            default:  line_d = 1'b0;
        endcase
    end

    assign o_ringbus     = line_q;
    assign o_busy        = busy_q;
    assign o_frames_sent = frames_q;

endmodule

// File: tb/tb_ringbus_tx.sv
// Randomized bench for ringbus_tx against a per-cycle expected-line queue model.
module tb_ringbus_tx;

    localparam int W = 32;
    localparam int G = 2;
`ifdef RINGBUS_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic          CLK = 1'b0;
    logic          MIB_MASTER_RESET;
    logic [W-1:0]  t0_data;
    logic          t0_valid;
    logic          t0_ready;
    logic          o_ringbus;
    logic          o_busy;
    logic [15:0]   o_frames_sent;

    int            n_tests = 0;
    int            n_fail  = 0;

    // Model: queue of line values for each cycle still owed by the frame in flight,
    // ending with the idle cycle that completes the frame.
    bit            model_q[$];
    logic [15:0]   m_frames;
    logic          m_line;

    ringbus_tx #(.WIDTH(W), .GAP(G)) dut (
        .CLK              (CLK),
        .MIB_MASTER_RESET (MIB_MASTER_RESET),
        .t0_data          (t0_data),
        .t0_valid         (t0_valid),
        .t0_ready         (t0_ready),
        .o_ringbus        (o_ringbus),
        .o_busy           (o_busy),
        .o_frames_sent    (o_frames_sent)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_frame(input logic [W-1:0] d);
        model_q.push_back(1'b1);
        for (int i = W - 1; i >= 0; i--) model_q.push_back(d[i]);
        if (P == 1) model_q.push_back(^d);
        for (int i = 0; i < G; i++) model_q.push_back(1'b0);
        model_q.push_back(1'b0);
    endfunction

    // Called at a falling edge; drives inputs, runs one clock, checks outputs.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        logic acc;
        t0_valid         = v;
        t0_data          = d;
        MIB_MASTER_RESET = r;
        #1;
        acc = v && (model_q.size() == 0) && !r;
        check_eq("t0_ready", 64'(t0_ready), 64'((model_q.size() == 0) && !r));
        @(posedge CLK);
        if (r) begin
            model_q.delete();
            m_frames = '0;
            m_line   = 1'b0;
        end else begin
            if (acc) push_frame(d);
            if (model_q.size() != 0) begin
                m_line = model_q.pop_front();
                if (model_q.size() == 0) m_frames = m_frames + 16'd1;
            end else begin
                m_line = 1'b0;
            end
        end
        @(negedge CLK);
        check_eq("o_ringbus", 64'(o_ringbus), 64'(m_line));
        check_eq("o_busy", 64'(o_busy), 64'(model_q.size() != 0));
        check_eq("o_frames_sent", 64'(o_frames_sent), 64'(m_frames));
    endtask

    initial begin
        t0_valid         = 1'b0;
        t0_data          = '0;
        MIB_MASTER_RESET = 1'b1;
        m_frames         = '0;
        m_line           = 1'b0;
        @(negedge CLK);
        repeat (3) step(1'b0, '0, 1'b1);

        // Single frame with edge bits set
        step(1'b1, W'(32'h80000001), 1'b0);
        repeat (40) step(1'b0, '1, 1'b0);

        // Back-to-back with valid held high
        step(1'b1, W'(32'hA5A5A5A5), 1'b0);
        repeat (36) step(1'b1, W'(32'h0000FFFF), 1'b0);
        repeat (40) step(1'b0, '0, 1'b0);

        // Reset pulse around data bit 10
        step(1'b1, W'($urandom), 1'b0);
        repeat (11) step(1'b0, W'($urandom), 1'b0);
        step(1'b0, '0, 1'b1);
        repeat (40) step(1'b0, '0, 1'b0);

        // Random traffic; data changes every cycle, occasional reset
        for (int n = 0; n < 2500; n++)
            step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 299) == 0);
        repeat (W + G + 8) step(1'b0, '0, 1'b0);

        // Counter wrap from a preloaded value
        dut.frames_q = 16'hFFFF;
        m_frames     = 16'hFFFF;
        #1;
        check_eq("preload", 64'(o_frames_sent), 64'(16'hFFFF));
        step(1'b1, W'($urandom), 1'b0);
        repeat (40) step(1'b0, W'($urandom), 1'b0);
        check_eq("frames_wrap", 64'(o_frames_sent), 64'(16'h0000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
